// File: rtl/calc_pkg.sv
// Shared calculator display definitions: controller state encoding and BCD nibble constants.
package calc_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned STATE_W  = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam logic [NIBBLE_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [NIBBLE_W-1:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble digit correction: adds 3 to a nibble of 5 or more before the next shift.
module bcd_adjust
    import calc_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    output logic [NIBBLE_W-1:0] digit_o
);

    // Nibble-local add; a corrected digit never exceeds 12, so no carry is lost.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock with start/done handshake.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned digits = 3
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [width-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*digits-1:0]   bcd_o
);

    localparam int unsigned SCR_W = NIBBLE_W * digits;
    localparam int unsigned CNT_W = $clog2(width + 1);
    localparam longint unsigned MAX_BIN  = (64'd1 << width) - 64'd1;
    localparam longint unsigned DEC_SPAN = 64'd10 ** digits;

    // The digit count must be able to represent the largest binary input.
    if (DEC_SPAN <= MAX_BIN) begin : g_digits_check
        $error("bin2bcd_seq: digits too small for width");
    end

    state_t             state_q, state_next;
    logic [width-1:0]   bin_q, bin_next;
    logic [SCR_W-1:0]   scratch_q, scratch_next, scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic [SCR_W-1:0]   bcd_next;
    logic               done_next;
    logic               busy_next;
    logic [SCR_W+width-1:0] shift_val;

    for (genvar g = 0; g < int'(digits); g++) begin : g_adj
        bcd_adjust u_adj (
            .digit_i (scratch_q[g*NIBBLE_W +: NIBBLE_W]),
            .digit_o (scratch_adj[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign shift_val = {scratch_adj, bin_q} << 1;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_o     <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_next;
            bin_q     <= bin_next;
            scratch_q <= scratch_next;
            cnt_q     <= cnt_next;
            bcd_o     <= bcd_next;
            done_o    <= done_next;
            busy_o    <= busy_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next   = state_q;
        bin_next     = bin_q;
        scratch_next = scratch_q;
        cnt_next     = cnt_q;
        bcd_next     = bcd_o;
        done_next    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_next     = bin_i;
                    scratch_next = '0;
                    cnt_next     = CNT_W'(width);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_next, bin_next} = shift_val;
                cnt_next = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next   = scratch_q;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double dabble) algorithm. It reads the registered binary result held in a dff_nbits operand/result register (q_o) and produces packed BCD digits for the display path. Start/done handshake with the calculator control FSM; one bit converted per clock.

Parameters:
width, 8, bit width of the binary input (unsigned)
digits, 3, number of BCD output digits; must satisfy 10^digits > 2^width - 1 (checked by elaboration-time assertion)

Ports:
clock_i  input  1  system clock, all state updates on rising edge
reset_i  input  1  synchronous reset, active-high
start_i  input  1  request conversion; sampled only in IDLE
bin_i  input  width  unsigned binary value, captured on the accepted start edge
busy_o  output  1  high while a conversion is in progress (SHIFT and DONE states)
done_o  output  1  single-cycle pulse: bcd_o holds the new result
bcd_o  output  4*digits  packed BCD, digit 0 in bits [3:0]; registered, holds last result

Behaviour:
- Reset (reset_i=1 at rising edge, any state): state=IDLE, bcd_o=0, done_o=0, busy_o=0, internal shift/scratch/counter registers cleared. Reset has priority over every other input.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy_o=0. On an edge with start_i=1: load bin_i into the binary shift register, clear the BCD scratch register, set counter=width, go to SHIFT. start_i=0: stay.
- SHIFT: each cycle, every scratch nibble >= 5 gets +3 (combinational, all nibbles in parallel), then {scratch, binreg} is shifted left by 1; counter decrements. When counter reaches 1 on this edge (last shift), go to DONE.
- DONE: bcd_o <= final scratch value; done_o=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start accepted at edge k. Shifts occur on edges k+1 .. k+width. done_o is high, and bcd_o is valid, after edge k+width+1. Example: width=8 gives 9 cycles from start edge to done_o.
- bcd_o is not modified during SHIFT. It keeps the previous result until the DONE update.
- start_i while busy_o=1 (SHIFT or DONE) is ignored. It is not queued. bin_i changes during conversion have no effect.
- Back-to-back: start_i held high through DONE is accepted on the first edge in IDLE. Throughput is one conversion per width+2 cycles.
- Reset asserted mid-conversion: the conversion is aborted, no done_o pulse, and bcd_o returns to 0.
- Arithmetic: scratch register is 4*digits bits and the add-3 is nibble-local (4-bit, no carry out). Counter width is clog2(width+1).

Decomposition:
- Shared package calc_pkg holds the FSM state typedef/localparams (IDLE, SHIFT, DONE) and the BCD nibble constants (ADJ_THRESH=5, ADJ_ADD=3). Other calculator display blocks reuse these.
- One sub-module: bcd_adjust, a combinational 4-bit function (in >= 5 ? in+3 : in), instantiated digits times via generate.

Test Plan:
- Reset then idle: reset_i=1 for 2 cycles -> bcd_o=12'h000, busy_o=0, done_o=0. No activity with start_i=0.
- Basic values (width=8, digits=3): bin_i=0 -> bcd_o=12'h000. 99 -> 12'h099. 255 -> 12'h255. 128 -> 12'h128. done_o pulses exactly 9 cycles after the start edge, and busy_o is high for 9 cycles.
- Start while busy: start bin_i=200, then pulse start_i with bin_i=17 three cycles later -> single done_o with bcd_o=12'h200. No second done without a new start in IDLE.
- Reset mid-conversion: start bin_i=173, assert reset_i at cycle 4 -> no done_o, bcd_o=12'h000, busy_o=0. A following start with 42 -> 12'h042.
- Back-to-back: start_i held high with bin_i=7 then 250 -> first done gives 12'h007, next done 10 cycles later gives 12'h250. bcd_o holds 12'h007 in between.
- Exhaustive sweep 0..255 against a reference model (integer /10, %10) -> all match.
